// File: rtl/uart_loader_pkg.sv
// ------------------------------------------------------------------
// uart_loader_pkg: opcodes and FSM state types for the UART loader
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_loader_pkg;

  localparam logic [7:0] LOADER_CMD_SET_ADDR = 8'h01;
  localparam logic [7:0] LOADER_CMD_WRITE    = 8'h02;
  localparam logic [7:0] LOADER_CMD_RUN      = 8'h03;
  localparam logic [7:0] LOADER_CMD_HALT     = 8'h04;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    PS_CMD     = 2'd0,
    PS_PAYLOAD = 2'd1,
    PS_EXEC    = 2'd2
  } parse_state_t;

  function automatic logic has_payload(input logic [7:0] op);
    return (op == LOADER_CMD_SET_ADDR) || (op == LOADER_CMD_WRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_loader_if.sv
// ------------------------------------------------------------------
// uart_loader_if: internal-RAM loader write port
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface uart_loader_if;
  logic        loader_we;
  logic [31:0] loader_addr;
  logic [31:0] loader_data;

  modport master (output loader_we, output loader_addr, output loader_data);
  modport slave  (input  loader_we, input  loader_addr, input  loader_data);
endinterface

`default_nettype wire

// File: rtl/uart_receive.sv
// ------------------------------------------------------------------
// uart_receive: 2-flop synchronizer + 8N1 deserializer, mid-bit sampling
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_receive
  import uart_loader_pkg::*;
#(
  parameter int BAUD_DIVIDE = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_error_pulse
);

  localparam int CNT_W = $clog2(BAUD_DIVIDE);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIVIDE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIVIDE - 1);

  logic [1:0]       sync;
  logic             rx_s;
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             valid_n, ferr_n;

  assign rx_s    = sync[1];
  assign rx_byte = shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync              <= 2'b11;
      state             <= RX_IDLE;
      cnt               <= '0;
      bit_idx           <= '0;
      shreg             <= '0;
      byte_valid        <= 1'b0;
      frame_error_pulse <= 1'b0;
    end else begin
      sync              <= {sync[0], rx};
      state             <= state_n;
      cnt               <= cnt_n;
      bit_idx           <= bit_idx_n;
      shreg             <= shreg_n;
      byte_valid        <= valid_n;
      frame_error_pulse <= ferr_n;
    end
  end

  // The half-bit start delay makes every later expiry land mid-bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_n = RX_START;
          cnt_n   = HALF_BIT;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_n = RX_IDLE;
          end else begin
            state_n   = RX_DATA;
            cnt_n     = FULL_BIT;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          shreg_n = {rx_s, shreg[7:1]};
          cnt_n   = FULL_BIT;
          if (bit_idx == 3'd7) begin
            state_n = RX_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          valid_n = rx_s;
          ferr_n  = !rx_s;
          state_n = RX_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/uart_loader.sv
// ------------------------------------------------------------------
// uart_loader: UART command stream -> RAM loader writes and core reset
// Optional feature macro: UART_LOADER_TIMEOUT_EN. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int BAUD_DIVIDE    = 434,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           uart_rx,
  uart_loader_if.master  loader,
  output logic           core_reset,
  output logic           frame_error
);

  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         rx_ferr;

  parse_state_t state, state_n;
  logic [7:0]   opcode, opcode_n;
  logic [1:0]   byte_cnt, byte_cnt_n;
  logic [31:0]  payload, payload_n;
  logic         we_r, we_n;
  logic [31:0]  addr_r, addr_n;
  logic [31:0]  data_r, data_n;
  logic         core_r, core_n;
  logic         ferr_r;
  logic         timeout;

  uart_receive #(
    .BAUD_DIVIDE(BAUD_DIVIDE)
  ) u_rx (
    .clk               (clk),
    .reset             (reset),
    .rx                (uart_rx),
    .byte_valid        (rx_valid),
    .rx_byte           (rx_byte),
    .frame_error_pulse (rx_ferr)
  );

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] idle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (rx_valid || (state != PS_PAYLOAD)) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + TMO_W'(1);
    end
  end

  assign timeout = (idle_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  assign loader.loader_we   = we_r;
  assign loader.loader_addr = addr_r;
  assign loader.loader_data = data_r;
  assign core_reset         = core_r;
  assign frame_error        = ferr_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PS_CMD;
      opcode   <= '0;
      byte_cnt <= '0;
      payload  <= '0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
      core_r   <= 1'b1;
      ferr_r   <= 1'b0;
    end else begin
      state    <= state_n;
      opcode   <= opcode_n;
      byte_cnt <= byte_cnt_n;
      payload  <= payload_n;
      we_r     <= we_n;
      addr_r   <= addr_n;
      data_r   <= data_n;
      core_r   <= core_n;
      ferr_r   <= ferr_r | rx_ferr;
    end
  end

  // Effects land on the edge that consumes the final byte; EXEC only
  // performs the post-write address increment, so the strobe sees the old address.
  always_comb begin
    state_n    = state;
    opcode_n   = opcode;
    byte_cnt_n = byte_cnt;
    payload_n  = payload;
    we_n       = 1'b0;
    addr_n     = addr_r;
    data_n     = data_r;
    core_n     = core_r;
    case (state)
      PS_CMD: begin
        if (rx_valid) begin
          opcode_n = rx_byte;
          if (has_payload(rx_byte)) begin
            state_n    = PS_PAYLOAD;
            byte_cnt_n = '0;
          end else if (rx_byte == LOADER_CMD_RUN) begin
            core_n  = 1'b0;
            state_n = PS_EXEC;
          end else if (rx_byte == LOADER_CMD_HALT) begin
            core_n  = 1'b1;
            state_n = PS_EXEC;
          end
        end
      end
      PS_PAYLOAD: begin
        if (rx_valid) begin
          payload_n  = {rx_byte, payload[31:8]};
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_n = PS_EXEC;
            if (opcode == LOADER_CMD_WRITE) begin
              we_n   = 1'b1;
              data_n = payload_n;
            end else begin
              addr_n = payload_n;
            end
          end
        end else if (timeout) begin
          state_n = PS_CMD;
        end
      end
      PS_EXEC: begin
        state_n = PS_CMD;
        if (opcode == LOADER_CMD_WRITE) begin
          addr_n = addr_r + 32'd4;
        end
      end
      default: state_n = PS_CMD;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_loader.sv
// ------------------------------------------------------------------
// tb_uart_loader: randomized command stream vs. byte-level loader model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_uart_loader;

  localparam int BAUD = 8;
  localparam int TMO  = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic core_reset;
  logic frame_error;

  uart_loader_if lb ();

  uart_loader #(
    .BAUD_DIVIDE    (BAUD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .loader      (lb),
    .core_reset  (core_reset),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the outputs must be in the current cycle.
  logic        exp_we, exp_core;
  logic [31:0] exp_addr, exp_data;
  logic [7:0]  byte_q[$];
  logic [7:0]  cmd_q[$];
  int          ferr_mode;
  int          idle_cycles;
  logic        prev_we;
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_we      = 1'b0;
    exp_core    = 1'b1;
    exp_addr    = 32'h0;
    exp_data    = 32'h0;
    byte_q.delete();
    cmd_q.delete();
    ferr_mode   = 0;
    idle_cycles = 0;
    prev_we     = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] word;
    idle_cycles = 0;
    if (cmd_q.size() == 0) begin
      if (b == 8'h01 || b == 8'h02) cmd_q.push_back(b);
      else if (b == 8'h03)          exp_core = 1'b0;
      else if (b == 8'h04)          exp_core = 1'b1;
    end else begin
      cmd_q.push_back(b);
      if (cmd_q.size() == 5) begin
        word = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
        if (cmd_q[0] == 8'h02) begin
          exp_we   = 1'b1;
          exp_data = word;
        end else begin
          exp_addr = word;
        end
        cmd_q.delete();
      end
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (reset) model_reset();
    check("loader_we",   32'(lb.loader_we), 32'(exp_we));
    check("loader_addr", lb.loader_addr, exp_addr);
    check("loader_data", lb.loader_data, exp_data);
    check("core_reset",  32'(core_reset), 32'(exp_core));
    if (ferr_mode == 0)      check("frame_error_clear", 32'(frame_error), 32'd0);
    else if (ferr_mode == 2) check("frame_error_sticky", 32'(frame_error), 32'd1);
    if (!reset) begin
      if (lb.loader_we) begin
        check("we_not_back_to_back", 32'(prev_we), 32'd0);
        seen_addr.push_back(lb.loader_addr);
        seen_data.push_back(lb.loader_data);
      end
      prev_we = lb.loader_we;
      if (exp_we) begin
        exp_we   = 1'b0;
        exp_addr = exp_addr + 32'd4;
      end
      if (dut.rx_valid) begin
        if (byte_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_byte_unexpected: got %h, required no byte at %0t", dut.rx_byte, $time);
        end else begin
          logic [7:0] b;
          b = byte_q.pop_front();
          n_cmp++;
          if (dut.rx_byte !== b) begin
            n_bad++;
            $display("FAIL rx_byte: got %h, required %h at %0t", dut.rx_byte, b, $time);
          end
          model_byte(b);
        end
      end
`ifdef UART_LOADER_TIMEOUT_EN
      else if (cmd_q.size() > 0) begin
        idle_cycles++;
        if (idle_cycles >= TMO) cmd_q.delete();
      end
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_period(input logic v);
    uart_rx = v;
    idle(BAUD);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
    if (stop_ok) byte_q.push_back(b);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop_ok);
    bit_period(1'b1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] w);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)));
  endtask

  task automatic clear_seen();
    seen_addr.delete();
    seen_data.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    reset = 1'b0;

    // Idle after reset
    idle(1000);
    check("idle_core_reset", 32'(core_reset), 32'd1);
    check("idle_addr", lb.loader_addr, 32'h0);

    // Address and two writes
    clear_seen();
    send_cmd(8'h01, 32'h0000_1000);
    send_cmd(8'h02, 32'hDEAD_BEEF);
    send_cmd(8'h02, 32'h1234_5678);
    idle(20);
    check("two_writes_count", 32'(seen_addr.size()), 32'd2);
    if (seen_addr.size() >= 2) begin
      check("write0_addr", seen_addr[0], 32'h0000_1000);
      check("write0_data", seen_data[0], 32'hDEAD_BEEF);
      check("write1_addr", seen_addr[1], 32'h0000_1004);
      check("write1_data", seen_data[1], 32'h1234_5678);
    end
    check("final_addr", lb.loader_addr, 32'h0000_1008);

    // Run / halt and address wrap
    send_byte(8'h03);
    idle(4);
    check("run_core_reset", 32'(core_reset), 32'd0);
    send_byte(8'h04);
    idle(4);
    check("halt_core_reset", 32'(core_reset), 32'd1);
    send_cmd(8'h01, 32'hFFFF_FFFC);
    clear_seen();
    send_cmd(8'h02, $urandom);
    idle(10);
    check("wrap_write_addr", seen_addr.size() > 0 ? seen_addr[0] : 32'h1, 32'hFFFF_FFFC);
    check("wrap_next_addr", lb.loader_addr, 32'h0);

    // Glitch and framing error
    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(100);
    ferr_mode = 1;
    send_byte(8'h55, 1'b0);
    idle(20);
    ferr_mode = 2;
    check("frame_error_set", 32'(frame_error), 32'd1);
    send_byte(8'h03);
    idle(4);
    check("run_after_ferr", 32'(core_reset), 32'd0);
    check("frame_error_kept", 32'(frame_error), 32'd1);

    // Ignored opcode and payload bytes that look like RUN
    send_byte(8'h04);
    clear_seen();
    send_byte(8'h7F);
    send_cmd(8'h02, 32'h0303_0303);
    idle(10);
    check("dataop_count", 32'(seen_addr.size()), 32'd1);
    check("dataop_data", seen_data.size() > 0 ? seen_data[0] : 32'h0, 32'h0303_0303);
    check("dataop_core_reset", 32'(core_reset), 32'd1);

    // Randomized command stream
    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      logic [31:0] w;
      r = $urandom_range(0, 9);
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = 32'hFFFF_FFF0 | (w & 32'hC);
      if (r <= 2)      send_cmd(8'h01, w);
      else if (r <= 6) send_cmd(8'h02, w);
      else if (r == 7) send_byte(8'h03);
      else if (r == 8) send_byte(8'h04);
      else             send_byte(8'($urandom_range(5, 255)));
      idle($urandom_range(0, 30));
    end

`ifdef UART_LOADER_TIMEOUT_EN
    // Abandoned partial command
    send_byte(8'h04);
    clear_seen();
    send_byte(8'h02);
    send_byte(8'hAA);
    idle(300);
    send_byte(8'h03);
    idle(10);
    check("timeout_no_write", 32'(seen_addr.size()), 32'd0);
    check("timeout_run", 32'(core_reset), 32'd0);
`endif

    // Asynchronous reset mid-payload
    send_byte(8'h02);
    send_byte(8'h11);
    idle(5);
    #2 reset = 1'b1;
    idle(3);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_addr", lb.loader_addr, 32'h0);
    check("rst_data", lb.loader_data, 32'h0);
    check("rst_we", 32'(lb.loader_we), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
    idle(20);
    clear_seen();
    send_cmd(8'h02, 32'hCAFE_F00D);
    idle(10);
    check("post_rst_count", 32'(seen_addr.size()), 32'd1);
    check("post_rst_addr", seen_addr.size() > 0 ? seen_addr[0] : 32'h1, 32'h0);
    check("post_rst_data", seen_data.size() > 0 ? seen_data[0] : 32'h0, 32'hCAFE_F00D);

    idle(50);
    check("bytes_outstanding", 32'(byte_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
